collision_latch: RTL and testbench
==================================

COLLISION_LATCH -- requirements
Module: collision_latch

Interface
REQ-001 Parameter SNAPSHOT_ON_VBLANK, default 1, selects the CPU view for collision registers: 1 = frame shadow, 0 = live latches.
REQ-002 raw_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pixel_valid  input  1  one-cycle strobe per visible pixel; object inputs are sampled only when high.
REQ-005 p0, p1, m0, m1, bl, pf  input  1 each  object pixel values for the current pixel.
REQ-006 hpos, vpos  input  10 each  current pixel coordinates.
REQ-007 in_vblank  input  1  vertical blank flag from the video timing source.
REQ-008 clear  input  1  one-cycle collision-clear strobe from the CPU bus.
REQ-009 rd_addr  input  4  register select.
REQ-010 rd_data  output  8  registered read data.

Function
REQ-011 Keep 15 live collision latches, one per object pair: M0-P1, M0-P0, M1-P0, M1-P1, P0-PF, P0-BL, P1-PF, P1-BL, M0-PF, M0-BL, M1-PF, M1-BL, BL-PF, P0-P1, M0-M1.
REQ-012 When pixel_valid is high and both objects of a pair are 1, set that pair's latch; it becomes visible on the following cycle.
REQ-013 Latches are sticky; they clear only on clear or reset.
REQ-014 If clear and a hit occur in the same cycle, clear wins; the latch reads 0 on the next cycle.
REQ-015 Register map, bit7/bit6: 0 = M0-P1/M0-P0; 1 = M1-P0/M1-P1; 2 = P0-PF/P0-BL; 3 = P1-PF/P1-BL; 4 = M0-PF/M0-BL; 5 = M1-PF/M1-BL; 6 = BL-PF/0; 7 = P0-P1/M0-M1. Bits 5:0 read 0.
REQ-016 First-hit capture: on the first P0-P1 hit after clear/reset, store hpos and vpos and set first_valid; later hits leave them unchanged until clear.
REQ-017 Address 8 = first hpos[7:0]; 9 = {first_valid, 5'b0, hpos[9:8]}; A = first vpos[7:0]; B = {6'b0, vpos[9:8]}.
REQ-018 Hit counter: 8-bit count of pixel_valid cycles with P0-P1 overlap.
REQ-019 The hit counter saturates at 255 and never wraps.
REQ-020 The hit counter is zeroed by clear.
REQ-021 Vblank rising edge (in_vblank 0 then 1 on consecutive cycles) copies all 15 live latches and the hit counter into a shadow set, then zeroes the live hit counter.
REQ-022 Live latches are not cleared at the vblank edge.
REQ-023 If clear coincides with the vblank edge, the shadow captures the pre-clear values and the live state clears.
REQ-024 Address C reads the shadow hit count.
REQ-025 Addresses 0-7 read the shadow set when SNAPSHOT_ON_VBLANK=1, otherwise the live latches.
REQ-026 Addresses D-F read 0x00.
REQ-027 rd_data is registered with one-cycle latency from rd_addr and reflects state as of the previous edge.
REQ-028 The block ignores pixel_valid while in_vblank is high.

Reset
REQ-029 Reset clears all latches, the shadow, first-hit registers, first_valid and the hit counter.
REQ-030 Reset sets the vblank edge detector history to 1, so no snapshot fires in the cycle after reset.
REQ-031 rd_data = 0x00 one cycle after reset is asserted.
REQ-032 Reset asserted mid-frame takes priority over clear, hits and snapshot in the same cycle.

Structure
REQ-033 The shared package holds register address constants (0x0-0xC) and collision bit-position constants.
REQ-034 The design is a single module with no sub-module; the pair logic is an indexed generate over a constant pair table.

Verification
REQ-035 After reset, p0=p1=1 with pixel_valid at hpos=100, vpos=50 -> next cycle: live P0-P1 set; regs 8/9/A/B = 0x64/0x80/0x32/0x00.
REQ-036 A second P0-P1 hit at hpos=200 -> first-hit registers unchanged; live count=2.
REQ-037 Pulse in_vblank 0->1 with SNAPSHOT_ON_VBLANK=1, then read addr 7 -> 0x80; addr C -> 0x02; live count 0.
REQ-038 Apply clear simultaneously with an m0&p0 hit -> addr 0 live reads 0x00; first_valid=0.
REQ-039 Apply 300 overlap pixels in one frame, then vblank -> addr C = 0xFF.
REQ-040 Apply reset mid-frame during an active hit -> all reads 0x00; no snapshot on the cycle after reset.

Source files
------------

// File: rtl/collision_latch_pkg.sv
// Shared constants for the collision latch: register addresses, pair bit
// positions, the object-pair table and the collision register packing.
package collision_latch_pkg;

    localparam int NUM_PAIRS = 15;

    localparam logic [3:0] ADDR_CXM0P     = 4'h0;
    localparam logic [3:0] ADDR_CXM1P     = 4'h1;
    localparam logic [3:0] ADDR_CXP0FB    = 4'h2;
    localparam logic [3:0] ADDR_CXP1FB    = 4'h3;
    localparam logic [3:0] ADDR_CXM0FB    = 4'h4;
    localparam logic [3:0] ADDR_CXM1FB    = 4'h5;
    localparam logic [3:0] ADDR_CXBLPF    = 4'h6;
    localparam logic [3:0] ADDR_CXPPMM    = 4'h7;
    localparam logic [3:0] ADDR_FIRST_HLO = 4'h8;
    localparam logic [3:0] ADDR_FIRST_HHI = 4'h9;
    localparam logic [3:0] ADDR_FIRST_VLO = 4'hA;
    localparam logic [3:0] ADDR_FIRST_VHI = 4'hB;
    localparam logic [3:0] ADDR_HIT_CNT   = 4'hC;

    localparam int CX_M0P1 = 0;
    localparam int CX_M0P0 = 1;
    localparam int CX_M1P0 = 2;
    localparam int CX_M1P1 = 3;
    localparam int CX_P0PF = 4;
    localparam int CX_P0BL = 5;
    localparam int CX_P1PF = 6;
    localparam int CX_P1BL = 7;
    localparam int CX_M0PF = 8;
    localparam int CX_M0BL = 9;
    localparam int CX_M1PF = 10;
    localparam int CX_M1BL = 11;
    localparam int CX_BLPF = 12;
    localparam int CX_P0P1 = 13;
    localparam int CX_M0M1 = 14;

    // Object indices into the packed {pf, bl, m1, m0, p1, p0} vector.
    localparam logic [2:0] OBJ_P0 = 3'd0;
    localparam logic [2:0] OBJ_P1 = 3'd1;
    localparam logic [2:0] OBJ_M0 = 3'd2;
    localparam logic [2:0] OBJ_M1 = 3'd3;
    localparam logic [2:0] OBJ_BL = 3'd4;
    localparam logic [2:0] OBJ_PF = 3'd5;

    function automatic logic [2:0] pair_a(input int idx);
        case (idx)
            CX_M0P1, CX_M0P0, CX_M0PF, CX_M0BL, CX_M0M1: pair_a = OBJ_M0;
            CX_M1P0, CX_M1P1, CX_M1PF, CX_M1BL:          pair_a = OBJ_M1;
            CX_P0PF, CX_P0BL, CX_P0P1:                   pair_a = OBJ_P0;
            CX_P1PF, CX_P1BL:                            pair_a = OBJ_P1;
            default:                                     pair_a = OBJ_BL;
        endcase
    endfunction

    function automatic logic [2:0] pair_b(input int idx);
        case (idx)
            CX_M0P1, CX_M1P1, CX_P0P1:                   pair_b = OBJ_P1;
            CX_M0P0, CX_M1P0:                            pair_b = OBJ_P0;
            CX_P0BL, CX_P1BL, CX_M0BL, CX_M1BL:          pair_b = OBJ_BL;
            CX_M0M1:                                     pair_b = OBJ_M1;
            default:                                     pair_b = OBJ_PF;
        endcase
    endfunction

    // Two latches per register in bits 7:6; register 6 has only one.
    function automatic logic [7:0] cx_reg(input logic [NUM_PAIRS-1:0] cx, input logic [2:0] r);
        case (r)
            3'd0:    cx_reg = {cx[CX_M0P1], cx[CX_M0P0], 6'b0};
            3'd1:    cx_reg = {cx[CX_M1P0], cx[CX_M1P1], 6'b0};
            3'd2:    cx_reg = {cx[CX_P0PF], cx[CX_P0BL], 6'b0};
            3'd3:    cx_reg = {cx[CX_P1PF], cx[CX_P1BL], 6'b0};
            3'd4:    cx_reg = {cx[CX_M0PF], cx[CX_M0BL], 6'b0};
            3'd5:    cx_reg = {cx[CX_M1PF], cx[CX_M1BL], 6'b0};
            3'd6:    cx_reg = {cx[CX_BLPF], 1'b0,        6'b0};
            default: cx_reg = {cx[CX_P0P1], cx[CX_M0M1], 6'b0};
        endcase
    endfunction

endpackage

// File: rtl/collision_latch.sv
// Sticky pairwise collision latches with first-hit capture, saturating
// P0-P1 hit counter and a vblank-edge shadow copy for the CPU read port.
module collision_latch
    import collision_latch_pkg::*;
#(
    parameter bit SNAPSHOT_ON_VBLANK = 1'b1
) (
    input  logic       raw_clk,
    input  logic       reset,
    input  logic       pixel_valid,
    input  logic       p0,
    input  logic       p1,
    input  logic       m0,
    input  logic       m1,
    input  logic       bl,
    input  logic       pf,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       in_vblank,
    input  logic       clear,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [5:0]           obj;
    logic                 pix_ok;
    logic [NUM_PAIRS-1:0] hit;
    logic [NUM_PAIRS-1:0] live_cx;
    logic [NUM_PAIRS-1:0] shadow_cx;
    logic [NUM_PAIRS-1:0] view_cx;
    logic [7:0]           hit_cnt;
    logic [7:0]           shadow_cnt;
    logic [9:0]           first_h;
    logic [9:0]           first_v;
    logic                 first_valid;
    logic                 vblank_prev;
    logic                 vb_edge;
    logic                 p0p1_hit;
    logic [7:0]           rd_next;

    assign obj    = {pf, bl, m1, m0, p1, p0};
    assign pix_ok = pixel_valid & ~in_vblank;

    for (genvar i = 0; i < NUM_PAIRS; i++) begin : g_pair
        assign hit[i] = pix_ok & obj[pair_a(i)] & obj[pair_b(i)];
    end

    assign p0p1_hit = hit[CX_P0P1];
    assign vb_edge  = in_vblank & ~vblank_prev;
    assign view_cx  = SNAPSHOT_ON_VBLANK ? shadow_cx : live_cx;

    always_comb begin
        rd_next = 8'h00;
        case (rd_addr)
            ADDR_CXM0P, ADDR_CXM1P, ADDR_CXP0FB, ADDR_CXP1FB,
            ADDR_CXM0FB, ADDR_CXM1FB, ADDR_CXBLPF, ADDR_CXPPMM:
                            rd_next = cx_reg(view_cx, rd_addr[2:0]);
            ADDR_FIRST_HLO: rd_next = first_h[7:0];
            ADDR_FIRST_HHI: rd_next = {first_valid, 5'b0, first_h[9:8]};
            ADDR_FIRST_VLO: rd_next = first_v[7:0];
            ADDR_FIRST_VHI: rd_next = {6'b0, first_v[9:8]};
            ADDR_HIT_CNT:   rd_next = shadow_cnt;
            default:        rd_next = 8'h00;
        endcase
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            live_cx     <= '0;
            shadow_cx   <= '0;
            hit_cnt     <= 8'h00;
            shadow_cnt  <= 8'h00;
            first_h     <= 10'd0;
            first_v     <= 10'd0;
            first_valid <= 1'b0;
            vblank_prev <= 1'b1;
            rd_data     <= 8'h00;
        end else begin
            vblank_prev <= in_vblank;
            rd_data     <= rd_next;
            // Shadow takes the pre-clear values when clear lands on the edge.
            if (vb_edge) begin
                shadow_cx  <= live_cx;
                shadow_cnt <= hit_cnt;
            end
            if (clear) begin
                live_cx     <= '0;
                hit_cnt     <= 8'h00;
                first_h     <= 10'd0;
                first_v     <= 10'd0;
                first_valid <= 1'b0;
            end else begin
                live_cx <= live_cx | hit;
                if (vb_edge)
                    hit_cnt <= 8'h00;
                else if (p0p1_hit && hit_cnt != 8'hFF)
                    hit_cnt <= hit_cnt + 8'd1;
                if (p0p1_hit && !first_valid) begin
                    first_h     <= hpos;
                    first_v     <= vpos;
                    first_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_collision_latch.sv
// Directed bench for collision_latch: one shadow-view and one live-view
// instance driven from the same stimulus.
module tb_collision_latch;

    logic       raw_clk = 1'b0;
    logic       reset = 1'b1;
    logic       pixel_valid = 1'b0;
    logic       p0 = 1'b0, p1 = 1'b0, m0 = 1'b0, m1 = 1'b0, bl = 1'b0, pf = 1'b0;
    logic [9:0] hpos = 10'd0, vpos = 10'd0;
    logic       in_vblank = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] rd_addr = 4'h0;
    logic [7:0] rd_data, rd_data_live;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 raw_clk = ~raw_clk;

    collision_latch dut (
        .raw_clk(raw_clk), .reset(reset), .pixel_valid(pixel_valid),
        .p0(p0), .p1(p1), .m0(m0), .m1(m1), .bl(bl), .pf(pf),
        .hpos(hpos), .vpos(vpos), .in_vblank(in_vblank), .clear(clear),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    collision_latch #(.SNAPSHOT_ON_VBLANK(1'b0)) dut_live (
        .raw_clk(raw_clk), .reset(reset), .pixel_valid(pixel_valid),
        .p0(p0), .p1(p1), .m0(m0), .m1(m1), .bl(bl), .pf(pf),
        .hpos(hpos), .vpos(vpos), .in_vblank(in_vblank), .clear(clear),
        .rd_addr(rd_addr), .rd_data(rd_data_live)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge raw_clk);
    endtask

    // One pixel strobe; object mask order is {pf, bl, m1, m0, p1, p0}.
    task automatic pix(input logic [5:0] mask, input logic [9:0] h, input logic [9:0] v);
        {pf, bl, m1, m0, p1, p0} = mask;
        hpos = h;
        vpos = v;
        pixel_valid = 1'b1;
        @(negedge raw_clk);
        {pf, bl, m1, m0, p1, p0} = 6'b0;
        pixel_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d_shadow, output logic [7:0] d_live);
        rd_addr = a;
        @(negedge raw_clk);
        d_shadow = rd_data;
        d_live   = rd_data_live;
    endtask

    task automatic vblank_pulse();
        in_vblank = 1'b1;
        idle(2);
        in_vblank = 1'b0;
        idle(1);
    endtask

    localparam logic [5:0] M_P0P1 = 6'b000011;
    localparam logic [5:0] M_P0M0 = 6'b000101;
    localparam logic [5:0] M_M0M1 = 6'b001100;
    localparam logic [5:0] M_P0BF = 6'b110001;
    localparam logic [5:0] M_M1P1 = 6'b001010;

    logic [7:0] ds, dl;

    initial begin
        // Reset and its one-cycle read latency
        idle(1);
        check("reset_rd_data", rd_data, 8'h00);
        idle(1);
        reset = 1'b0;
        for (int a = 0; a <= 12; a++) begin
            rd(4'(a), ds, dl);
            check($sformatf("reset_addr%0d", a), ds, 8'h00);
        end

        // First P0-P1 hit at (100, 50)
        pix(M_P0P1, 10'd100, 10'd50);
        rd(4'h7, ds, dl);
        check("live_p0p1_set", dl, 8'h80);
        check("shadow_p0p1_pre_vblank", ds, 8'h00);
        rd(4'h8, ds, dl); check("first_hlo", ds, 8'h64);
        rd(4'h9, ds, dl); check("first_hhi", ds, 8'h80);
        rd(4'hA, ds, dl); check("first_vlo", ds, 8'h32);
        rd(4'hB, ds, dl); check("first_vhi", ds, 8'h00);

        // Second hit leaves first-hit capture alone
        pix(M_P0P1, 10'd200, 10'd60);
        rd(4'h8, ds, dl); check("first_hlo_kept", ds, 8'h64);
        rd(4'hA, ds, dl); check("first_vlo_kept", ds, 8'h32);

        // Vblank edge snapshot; pixel during vblank ignored
        in_vblank = 1'b1;
        idle(1);
        pix(M_M0M1, 10'd5, 10'd5);
        in_vblank = 1'b0;
        idle(1);
        rd(4'h7, ds, dl);
        check("shadow_addr7", ds, 8'h80);
        check("live_kept_no_vblank_hit", dl, 8'h80);
        rd(4'hC, ds, dl); check("shadow_cnt_2", ds, 8'h02);
        vblank_pulse();
        rd(4'hC, ds, dl); check("live_cnt_zeroed", ds, 8'h00);
        rd(4'h7, ds, dl); check("live_kept_after_vblank", dl, 8'h80);

        // Clear coincident with an M0-P0 hit
        clear = 1'b1;
        pix(M_P0M0, 10'd7, 10'd7);
        clear = 1'b0;
        rd(4'h0, ds, dl); check("clear_wins_addr0", dl, 8'h00);
        rd(4'h7, ds, dl); check("clear_live_addr7", dl, 8'h00);
        rd(4'h9, ds, dl); check("clear_first_valid", ds, 8'h00);

        // Other object pairs
        pix(M_P0M0, 10'd8, 10'd8);
        rd(4'h0, ds, dl); check("m0p0_addr0", dl, 8'h40);
        pix(M_P0BF, 10'd9, 10'd8);
        rd(4'h2, ds, dl); check("p0pf_p0bl_addr2", dl, 8'hC0);
        rd(4'h6, ds, dl); check("blpf_addr6", dl, 8'h80);
        pix(M_M1P1, 10'd10, 10'd8);
        rd(4'h1, ds, dl); check("m1p1_addr1", dl, 8'h40);
        rd(4'h3, ds, dl); check("p1_none_addr3", dl, 8'h00);

        // Clear on the vblank edge: shadow sees pre-clear state
        pix(M_P0P1, 10'd10, 10'd5);
        pix(M_P0P1, 10'd20, 10'd5);
        pix(M_P0P1, 10'd30, 10'd5);
        rd(4'h8, ds, dl); check("first_hlo_10", ds, 8'h0A);
        in_vblank = 1'b1;
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        in_vblank = 1'b0;
        idle(1);
        rd(4'hC, ds, dl); check("edge_clear_shadow_cnt", ds, 8'h03);
        rd(4'h7, ds, dl);
        check("edge_clear_shadow_addr7", ds, 8'h80);
        check("edge_clear_live_addr7", dl, 8'h00);
        rd(4'h0, ds, dl); check("edge_clear_shadow_addr0", ds, 8'h40);
        rd(4'h2, ds, dl); check("edge_clear_shadow_addr2", ds, 8'hC0);
        rd(4'h9, ds, dl); check("edge_clear_first_valid", ds, 8'h00);

        // 300 overlaps saturate at 255; first hit has high coordinate bits
        pix(M_P0P1, 10'h2A5, 10'h301);
        for (int i = 1; i < 300; i++) pix(M_P0P1, 10'(i), 10'd400);
        rd(4'h8, ds, dl); check("hi_first_hlo", ds, 8'hA5);
        rd(4'h9, ds, dl); check("hi_first_hhi", ds, 8'h82);
        rd(4'hA, ds, dl); check("hi_first_vlo", ds, 8'h01);
        rd(4'hB, ds, dl); check("hi_first_vhi", ds, 8'h03);
        vblank_pulse();
        rd(4'hC, ds, dl); check("saturated_cnt", ds, 8'hFF);
        rd(4'hD, ds, dl); check("addr_d_zero", ds, 8'h00);
        rd(4'hE, ds, dl); check("addr_e_zero", ds, 8'h00);
        rd(4'hF, ds, dl); check("addr_f_zero", ds, 8'h00);

        // Reset mid-frame with a hit, vblank rise and clear all pending
        rd_addr = 4'hC;
        {p1, p0} = 2'b11;
        pixel_valid = 1'b1;
        hpos = 10'd50;
        vpos = 10'd50;
        in_vblank = 1'b1;
        clear = 1'b1;
        reset = 1'b1;
        @(negedge raw_clk);
        check("reset_mid_rd_data", rd_data, 8'h00);
        {p1, p0} = 2'b00;
        pixel_valid = 1'b0;
        clear = 1'b0;
        reset = 1'b0;
        idle(1);
        in_vblank = 1'b0;
        for (int a = 0; a <= 12; a++) begin
            rd(4'(a), ds, dl);
            check($sformatf("post_reset_shadow%0d", a), ds, 8'h00);
            check($sformatf("post_reset_live%0d", a), dl, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
